pwm_peripheral: RTL and testbench
=================================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PRESCALE, default 13: system-clock cycles per PWM count tick; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enables for out[7:0], from the SPI register stage.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enables for out[15:8].
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM-mode selects for out[7:0].
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM-mode selects for out[15:8].
REQ-008 SHALL have port pwm_duty_cycle  input  8  duty value; high fraction = duty/256, except 0xFF = 100 %.
REQ-009 SHALL have port out  output  16  registered drive pins.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse, asserted on the clk cycle when the PWM count wraps to 0.

Function
REQ-011 SHALL contain a prescale counter (16 bit) counting 0..PRESCALE-1; tick asserts on the cycle it equals PRESCALE-1, then it returns to 0.
REQ-012 SHALL contain an 8-bit PWM count that increments on each tick and wraps from 255 to 0; period = 256*PRESCALE clk cycles.
REQ-013 SHALL assert period_start for exactly one cycle, registered, on the cycle after the tick that wraps the PWM count from 255 to 0.
REQ-014 SHALL compute pwm_sig = 1 if effective duty == 0xFF, else (pwm count < effective duty); duty 0x00 gives constant 0.
REQ-015 SHALL compute for each bit i: out[i] = en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0, where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm is concatenated the same way.
REQ-016 SHALL register out, giving 1 clk of latency from any enable change to the pin.
REQ-017 SHALL give en_pwm no effect on a bit whose en_out is 0; that bit SHALL stay 0.
REQ-018 SHALL register all inputs directly from the clk domain, with no synchronizers; the upstream stage is already synchronous to clk.
REQ-019 SHALL keep the prescale and PWM counters free-running regardless of enable values.
REQ-020 SHALL produce no glitches: out changes only on clk edges.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, clear the prescale counter, PWM count, out (0x0000), period_start (0) and the shadow duty (0x00).
REQ-022 SHALL begin counting on the first clk edge with rst=0; the first tick occurs PRESCALE cycles after reset release.
REQ-023 SHALL, on reset asserted mid-period, force out to 0x0000 at that same edge and discard the shadow duty.

Configuration
REQ-024 SHALL support macro PWM_SHADOW_DUTY_EN.
REQ-025 SHALL, with PWM_SHADOW_DUTY_EN defined, load the effective duty from pwm_duty_cycle only on the cycle the PWM count wraps to 0, so a mid-period change first takes effect in the next full period.
REQ-026 SHALL, without PWM_SHADOW_DUTY_EN, make the effective duty equal pwm_duty_cycle combinationally, so a mid-period change takes effect on the next compare (next clk).

Verification
REQ-027 SHALL cover: PRESCALE=1, en_out=0x0001, en_pwm=0x0001, duty=0x80 -> out[0] high 128 clk, low 128 clk, repeating; period_start every 256 clk.
REQ-028 SHALL cover: duty=0x00 then 0xFF with bit 3 enabled in PWM mode -> out[3] constant 0, then constant 1 with no low cycle across a wrap.
REQ-029 SHALL cover: en_out=0xA5A5, en_pwm=0x0000 -> out=0xA5A5 one clk after the inputs settle; en_out=0x0000, en_pwm=0xFFFF -> out=0x0000.
REQ-030 SHALL cover: PWM_SHADOW_DUTY_EN defined, duty changed 0x40->0xC0 at PWM count 100 -> current period stays high 64 counts, next period high 192 counts; without the macro, high resumes at count 101 for that period.
REQ-031 SHALL cover: PRESCALE=13, duty=0x80 -> high 1664 clk, period 3328 clk.
REQ-032 SHALL cover: rst pulsed at PWM count 200 with out=0xFFFF -> out=0x0000 at that edge; first tick 13 clk after release with the default PRESCALE.

Source files
------------

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM / static output driver.
//
// A free-running prescaler divides clk by PRESCALE to produce a count tick;
// an 8-bit PWM count advances on each tick, so one PWM period is
// 256*PRESCALE clk cycles. Each output bit is either forced low (disabled),
// driven static high (enabled, not in PWM mode) or follows the shared PWM
// waveform (enabled, PWM mode). All outputs are registered.
//
// Optional feature macro: PWM_SHADOW_DUTY_EN
//   defined   -> duty is captured into a shadow register on each period wrap,
//                so a mid-period duty change first shows in the next period.
//   undefined -> duty input is used directly on every compare.
//
// The block has no state machine and no handshake: every input is a plain
// level already synchronous to clk, so no synchronizers are used.

module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_cnt;
  logic [7:0]  pwm_cnt;
  logic        tick;
  logic        wrap;
  logic [7:0]  duty_eff;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Tick on the last prescale cycle; wrap when that tick also rolls 255 -> 0.
  assign tick = (presc_cnt == PRESCALE_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Prescale counter: free-running 0..PRESCALE-1, independent of enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  // PWM count: advances once per tick and wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Period marker: high for the single cycle in which the count reads 0
  // right after a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

`ifdef PWM_SHADOW_DUTY_EN
  logic [7:0] duty_shadow;

  // Shadow duty: sampled only at the wrap so each period uses one stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow <= '0;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  // 0xFF is treated as 100 % so full-on never shows a low cycle at count 255.
  assign pwm_sig = (duty_eff == 8'hFF) || (pwm_cnt < duty_eff);

  // Per-bit output select: disabled bits stay low whatever the PWM select says.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < 16; i++) begin
      if (en_out[i]) begin
        out_next[i] = en_pwm[i] ? pwm_sig : 1'b1;
      end
    end
  end

  // Output register: pins only change on clk edges, reset forces all low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: self-checking bench for pwm_peripheral.
// Two instances share all inputs: one with the default PRESCALE (13) and one
// with PRESCALE=1. A cycle-count reference model predicts both every cycle.

module tb_pwm_peripheral;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;

  logic [15:0] out13, out1;
  logic        ps13, ps1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef PWM_SHADOW_DUTY_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  pwm_peripheral dut13 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out13),
    .period_start    (ps13)
  );

  pwm_peripheral #(.PRESCALE(1)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out1),
    .period_start    (ps1)
  );

  // ---------------- reference model ----------------
  // k = number of clk edges seen since reset released. Before edge k+1 the
  // PWM count is (k / P) mod 256; the pin after that edge reflects it.
  int unsigned k13 = 0, k1 = 0;
  logic [7:0]  sh13 = '0, sh1 = '0;
  logic [15:0] exp13 = '0, exp1 = '0;
  logic        eps13 = 1'b0, eps1 = 1'b0;

  function automatic logic [15:0] model_out(int unsigned k, int unsigned p,
                                            logic [7:0] d, logic [15:0] eo,
                                            logic [15:0] ep);
    int unsigned cnt;
    logic        sig;
    logic [15:0] r;
    cnt = (k / p) % 256;
    sig = (d == 8'hFF) || (cnt < 32'(d));
    for (int i = 0; i < 16; i++) r[i] = eo[i] && (ep[i] ? sig : 1'b1);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k13 <= 0; sh13 <= '0; exp13 <= '0; eps13 <= 1'b0;
    end else begin
      k13   <= k13 + 1;
      exp13 <= model_out(k13, 13, SHADOW ? sh13 : duty, en_out, en_pwm);
      eps13 <= ((k13 + 1) % (256 * 13)) == 0;
      if (((k13 + 1) % (256 * 13)) == 0) sh13 <= duty;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      k1 <= 0; sh1 <= '0; exp1 <= '0; eps1 <= 1'b0;
    end else begin
      k1   <= k1 + 1;
      exp1 <= model_out(k1, 1, SHADOW ? sh1 : duty, en_out, en_pwm);
      eps1 <= ((k1 + 1) % 256) == 0;
      if (((k1 + 1) % 256) == 0) sh1 <= duty;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en_out = 16'hFFFF; en_pwm = '0; duty = 8'hFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out13, ps13, out1, ps1} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_state out13=%h ps13=%b out1=%h ps1=%b required all 0",
               out13, ps13, out1, ps1);
    end
  endtask

  task automatic test_static_enables();
    rst = 1'b0; en_out = 16'hA5A5; en_pwm = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (out13 !== 16'hA5A5 || out1 !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL static_a5a5 out13=%h out1=%h required a5a5", out13, out1);
    end
    en_out = 16'h0000; en_pwm = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if (out13 !== 16'h0000 || out1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL pwm_without_enable out13=%h out1=%h required 0000", out13, out1);
    end
    for (int i = 0; i < 60; i++) begin
      en_out = 16'($urandom); en_pwm = 16'($urandom); duty = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if ({out13, ps13, out1, ps1} !== {exp13, eps13, exp1, eps1}) begin
        n_fail++;
        $display("FAIL random_enables out13=%h/%b out1=%h/%b required %h/%b %h/%b",
                 out13, ps13, out1, ps1, exp13, eps13, exp1, eps1);
      end
    end
  endtask

  task automatic test_half_duty_p1();
    bit found = 0;
    int high_cnt = 0;
    int ps_cnt = 0;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (ps1) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL half_p1_wait period_start never seen in 600 clk");
    end
    for (int j = 1; j <= 512; j++) begin
      @(negedge clk);
      if (out1[0]) high_cnt++;
      if (ps1) ps_cnt++;
      n_checks++;
      if ({out13, ps13, out1, ps1} !== {exp13, eps13, exp1, eps1}) begin
        n_fail++;
        $display("FAIL half_p1_model out1=%h/%b required %h/%b out13=%h/%b required %h/%b",
                 out1, ps1, exp1, eps1, out13, ps13, exp13, eps13);
      end
      if (j == 256) begin
        n_checks++;
        if (high_cnt !== 128 || ps1 !== 1'b1) begin
          n_fail++;
          $display("FAIL half_p1_period1 high=%0d ps=%b required 128 and 1", high_cnt, ps1);
        end
      end
    end
    n_checks++;
    if (high_cnt !== 256 || ps_cnt !== 2) begin
      n_fail++;
      $display("FAIL half_p1_two_periods high=%0d ps=%0d required 256 and 2", high_cnt, ps_cnt);
    end
  endtask

  task automatic test_duty_extremes();
    int bad;
    bit found;
    en_out = 16'h0008; en_pwm = 16'h0008;
    for (int pass = 0; pass < 2; pass++) begin
      duty  = (pass == 0) ? 8'h00 : 8'hFF;
      found = 0;
      bad   = 0;
      for (int i = 0; i < 600 && !found; i++) begin
        @(negedge clk);
        if (ps1) found = 1;
      end
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL extremes_wait pass=%0d period_start never seen", pass);
      end
      for (int j = 0; j < 600; j++) begin
        @(negedge clk);
        if (out1[3] !== (pass == 1)) bad++;
        n_checks++;
        if ({out13, ps13, out1, ps1} !== {exp13, eps13, exp1, eps1}) begin
          n_fail++;
          $display("FAIL extremes_model out1=%h/%b required %h/%b out13=%h/%b required %h/%b",
                   out1, ps1, exp1, eps1, out13, ps13, exp13, eps13);
        end
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL extremes_constant duty=%h wrong_cycles=%0d required 0", duty, bad);
      end
    end
  endtask

  task automatic test_midperiod_change();
    bit found = 0;
    int high_cur = 0;
    int high_next = 0;
    int exp_cur;
    exp_cur = SHADOW ? 64 : (64 + 192 - 100);
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h40;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (ps1) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midperiod_wait period_start never seen");
    end
    for (int j = 1; j <= 512; j++) begin
      @(negedge clk);
      if (j <= 256 && out1[0]) high_cur++;
      if (j > 256 && out1[0]) high_next++;
      n_checks++;
      if ({out13, ps13, out1, ps1} !== {exp13, eps13, exp1, eps1}) begin
        n_fail++;
        $display("FAIL midperiod_model out1=%h/%b required %h/%b out13=%h/%b required %h/%b",
                 out1, ps1, exp1, eps1, out13, ps13, exp13, eps13);
      end
      if (j == 100) duty = 8'hC0;
    end
    n_checks++;
    if (high_cur !== exp_cur || high_next !== 192) begin
      n_fail++;
      $display("FAIL midperiod_counts cur=%0d next=%0d required %0d and 192",
               high_cur, high_next, exp_cur);
    end
  endtask

  task automatic test_prescale13();
    bit found = 0;
    int high_cnt = 0;
    int ps_at = 0;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    for (int i = 0; i < 3500 && !found; i++) begin
      @(negedge clk);
      if (ps13) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL p13_wait period_start never seen in 3500 clk");
    end
    for (int j = 1; j <= 3328; j++) begin
      @(negedge clk);
      if (out13[0]) high_cnt++;
      if (ps13 && ps_at == 0) ps_at = j;
      n_checks++;
      if ({out13, ps13, out1, ps1} !== {exp13, eps13, exp1, eps1}) begin
        n_fail++;
        $display("FAIL p13_model out13=%h/%b required %h/%b out1=%h/%b required %h/%b",
                 out13, ps13, exp13, eps13, out1, ps1, exp1, eps1);
      end
    end
    n_checks++;
    if (high_cnt !== 1664 || ps_at !== 3328) begin
      n_fail++;
      $display("FAIL p13_period high=%0d next_ps_at=%0d required 1664 and 3328",
               high_cnt, ps_at);
    end
  endtask

  task automatic test_reset_midperiod();
    bit found = 0;
    int high_early = 0;
    int ps_at = 0;
    en_out = 16'hFFFF; en_pwm = 16'h0000;
    for (int i = 0; i < 3500 && !found; i++) begin
      @(negedge clk);
      if (((k13 / 13) % 256) == 200) found = 1;
    end
    n_checks++;
    if (!found || out13 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL rst_mid_setup reached=%b out13=%h required 1 and ffff", found, out13);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out13, ps13, out1, ps1} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_mid_clear out13=%h out1=%h required 0000", out13, out1);
    end
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h01;
    rst = 1'b0;
    for (int j = 1; j <= 3400; j++) begin
      @(negedge clk);
      if (j <= 40 && out13[0]) high_early++;
      if (ps13 && ps_at == 0) ps_at = j;
      n_checks++;
      if ({out13, ps13, out1, ps1} !== {exp13, eps13, exp1, eps1}) begin
        n_fail++;
        $display("FAIL rst_mid_model out13=%h/%b required %h/%b out1=%h/%b required %h/%b",
                 out13, ps13, exp13, eps13, out1, ps1, exp1, eps1);
      end
    end
    n_checks++;
    if (high_early !== (SHADOW ? 0 : 13) || ps_at !== 3328) begin
      n_fail++;
      $display("FAIL rst_mid_first_tick high=%0d first_ps=%0d required %0d and 3328",
               high_early, ps_at, SHADOW ? 0 : 13);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_static_enables();
    test_half_duty_p1();
    test_duty_extremes();
    test_midperiod_change();
    test_prescale13();
    test_reset_midperiod();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
